alu_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters: port 0 is the main execute stage and port 1 is the branch/address helper.
- Each request carries operands A and B plus a 4-bit ALU control code.
- The block grants requests round-robin, presents the latched operands to the ALU for one cycle, then captures the result and zero flag.
- It returns them to the granting requester over a valid/ready response handshake.
- It sits between the pipeline control logic and the alu instance, and drives all of the ALU's inputs.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_arbiter_rr_pick2.sv | 22 ++
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its arbiter.
//   alu_ctrl_t  : 4-bit ALU control code
//   ALU_*       : supported control codes
//   arb_state_t : arbiter FSM states
package alu_pkg;

  typedef logic [3:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_AND = 4'd0;
  localparam alu_ctrl_t ALU_OR  = 4'd1;
  localparam alu_ctrl_t ALU_ADD = 4'd2;
  localparam alu_ctrl_t ALU_SUB = 4'd6;
  localparam alu_ctrl_t ALU_SLT = 4'd7;
  localparam alu_ctrl_t ALU_NOR = 4'd12;
  localparam alu_ctrl_t ALU_XOR = 4'd13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-input round-robin picker.
//   valid0/valid1 : requester valids
//   last_grant    : id of the requester granted last (0 or 1)
//   grant         : one-hot grant, all zero when nobody is valid
module rr_pick2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (valid0 && valid1) begin
      // Contention goes to whoever did not win last time.
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = {valid1, valid0};
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters (0: execute stage,
// 1: branch/address helper). A granted request's operands are registered
// onto the ALU inputs for one cycle, the result and zero flag are captured,
// and returned over a valid/ready response handshake.
//   i_clk, i_rst                    : clock, synchronous active-high reset
//   i_con_Req*Valid/o_con_Req*Ready : request handshake per requester
//   i_data_Req*A/B, i_con_Req*Ctrl  : request operands and control code
//   o_con_Rsp*Valid/i_con_Rsp*Ready : response handshake per requester
//   o_data_Rsp*Res, o_con_Rsp*Zero  : response result and zero flag
//   o_data_AluA/B, o_con_AluCtrl    : to the ALU
//   i_data_AluRes, i_con_AluZero    : from the ALU
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_con_Req0Valid,
  input  logic [DATA_W-1:0] i_data_Req0A,
  input  logic [DATA_W-1:0] i_data_Req0B,
  input  logic [CTRL_W-1:0] i_con_Req0Ctrl,
  output logic              o_con_Req0Ready,
  input  logic              i_con_Req1Valid,
  input  logic [DATA_W-1:0] i_data_Req1A,
  input  logic [DATA_W-1:0] i_data_Req1B,
  input  logic [CTRL_W-1:0] i_con_Req1Ctrl,
  output logic              o_con_Req1Ready,
  output logic              o_con_Rsp0Valid,
  output logic [DATA_W-1:0] o_data_Rsp0Res,
  output logic              o_con_Rsp0Zero,
  input  logic              i_con_Rsp0Ready,
  output logic              o_con_Rsp1Valid,
  output logic [DATA_W-1:0] o_data_Rsp1Res,
  output logic              o_con_Rsp1Zero,
  input  logic              i_con_Rsp1Ready,
  output logic [DATA_W-1:0] o_data_AluA,
  output logic [DATA_W-1:0] o_data_AluB,
  output logic [CTRL_W-1:0] o_con_AluCtrl,
  input  logic [DATA_W-1:0] i_data_AluRes,
  input  logic              i_con_AluZero
);

  arb_state_t state;
  logic       last_grant;
  logic       gnt_id;
  logic [1:0] pick;
  logic       rsp_take;

  rr_pick2 u_pick (
    .valid0     (i_con_Req0Valid),
    .valid1     (i_con_Req1Valid),
    .last_grant (last_grant),
    .grant      (pick)
  );

  assign o_con_Req0Ready = (state == IDLE) && pick[0];
  assign o_con_Req1Ready = (state == IDLE) && pick[1];

  // Only the granted port's response ready can retire the transaction.
  always_comb begin
    rsp_take = gnt_id ? i_con_Rsp1Ready : i_con_Rsp0Ready;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      gnt_id          <= 1'b0;
      o_data_AluA     <= '0;
      o_data_AluB     <= '0;
      o_con_AluCtrl   <= '0;
      o_con_Rsp0Valid <= 1'b0;
      o_data_Rsp0Res  <= '0;
      o_con_Rsp0Zero  <= 1'b0;
      o_con_Rsp1Valid <= 1'b0;
      o_data_Rsp1Res  <= '0;
      o_con_Rsp1Zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick[0]) begin
            o_data_AluA   <= i_data_Req0A;
            o_data_AluB   <= i_data_Req0B;
            o_con_AluCtrl <= i_con_Req0Ctrl;
            gnt_id        <= 1'b0;
            last_grant    <= 1'b0;
            state         <= EXEC;
          end else if (pick[1]) begin
            o_data_AluA   <= i_data_Req1A;
            o_data_AluB   <= i_data_Req1B;
            o_con_AluCtrl <= i_con_Req1Ctrl;
            gnt_id        <= 1'b1;
            last_grant    <= 1'b1;
            state         <= EXEC;
          end
        end
        EXEC: begin
          if (!gnt_id) begin
            o_data_Rsp0Res  <= i_data_AluRes;
            o_con_Rsp0Zero  <= i_con_AluZero;
            o_con_Rsp0Valid <= 1'b1;
          end else begin
            o_data_Rsp1Res  <= i_data_AluRes;
            o_con_Rsp1Zero  <= i_con_AluZero;
            o_con_Rsp1Valid <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_take) begin
            if (!gnt_id) o_con_Rsp0Valid <= 1'b0;
            else         o_con_Rsp1Valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: table of single transactions plus
// hand-written sequences for contention, response backpressure and reset.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
  logic [31:0] rsp0_res, rsp1_res;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(32), .CTRL_W(4)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_con_Req0Valid (req0_valid),
    .i_data_Req0A    (req0_a),
    .i_data_Req0B    (req0_b),
    .i_con_Req0Ctrl  (req0_ctrl),
    .o_con_Req0Ready (req0_ready),
    .i_con_Req1Valid (req1_valid),
    .i_data_Req1A    (req1_a),
    .i_data_Req1B    (req1_b),
    .i_con_Req1Ctrl  (req1_ctrl),
    .o_con_Req1Ready (req1_ready),
    .o_con_Rsp0Valid (rsp0_valid),
    .o_data_Rsp0Res  (rsp0_res),
    .o_con_Rsp0Zero  (rsp0_zero),
    .i_con_Rsp0Ready (rsp0_ready),
    .o_con_Rsp1Valid (rsp1_valid),
    .o_data_Rsp1Res  (rsp1_res),
    .o_con_Rsp1Zero  (rsp1_zero),
    .i_con_Rsp1Ready (rsp1_ready),
    .o_data_AluA     (alu_a),
    .o_data_AluB     (alu_b),
    .o_con_AluCtrl   (alu_ctrl),
    .i_data_AluRes   (alu_res),
    .i_con_AluZero   (alu_zero)
  );

  // Reference ALU attached to the arbiter's ALU port.
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      4'd0:  alu_res = alu_a & alu_b;
      4'd1:  alu_res = alu_a | alu_b;
      4'd2:  alu_res = alu_a + alu_b;
      4'd6:  alu_res = alu_a - alu_b;
      4'd7:  alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'd12: alu_res = ~(alu_a | alu_b);
      4'd13: alu_res = alu_a ^ alu_b;
      default: alu_res = '0;
    endcase
    alu_zero = (alu_res == '0);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Runs one isolated transaction; entered and left just after a negedge with the DUT idle.
  task automatic do_txn(input logic port, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] ctrl, input logic [31:0] exp_res, input logic exp_zero);
    if (!port) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = ctrl;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = ctrl;
    end
    #1;
    check("txn_req_ready", {31'd0, port ? req1_ready : req0_ready}, 32'd1);
    check("txn_other_ready", {31'd0, port ? req0_ready : req1_ready}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("txn_alu_a", alu_a, a);
    check("txn_alu_b", alu_b, b);
    check("txn_alu_ctrl", {28'd0, alu_ctrl}, {28'd0, ctrl});
    check("txn_rsp_early", {31'd0, port ? rsp1_valid : rsp0_valid}, 32'd0);
    @(negedge clk);
    check("txn_rsp_valid", {31'd0, port ? rsp1_valid : rsp0_valid}, 32'd1);
    check("txn_rsp_res", port ? rsp1_res : rsp0_res, exp_res);
    check("txn_rsp_zero", {31'd0, port ? rsp1_zero : rsp0_zero}, {31'd0, exp_zero});
    check("txn_rsp_other", {31'd0, port ? rsp0_valid : rsp1_valid}, 32'd0);
    if (!port) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    check("txn_rsp_clear", {31'd0, port ? rsp1_valid : rsp0_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        port;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int grants;
    int order[4];
    logic got_rsp0, got_rsp1;

    vecs[0] = '{1'b0, 32'd5,        32'd3,        4'd2,  32'd8,          1'b0};
    vecs[1] = '{1'b0, 32'd7,        32'd7,        4'd6,  32'd0,          1'b1};
    vecs[2] = '{1'b1, 32'h0000_00F0, 32'h0000_000F, 4'd1, 32'h0000_00FF, 1'b0};
    vecs[3] = '{1'b0, 32'd2,        32'd9,        4'd7,  32'd1,          1'b0};
    vecs[4] = '{1'b0, 32'd123,      32'd45,       4'd9,  32'd0,          1'b1};
    vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'd1,       4'd7,  32'd1,          1'b0};
    vecs[6] = '{1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'd12, 32'h0000_0000, 1'b1};
    vecs[7] = '{1'b0, 32'hAAAA_5555, 32'hFFFF_0000, 4'd13, 32'h5555_5555, 1'b0};
    vecs[8] = '{1'b1, 32'hDEAD_BEEF, 32'h0000_FFFF, 4'd0,  32'h0000_BEEF, 1'b0};

    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_a = '0; req1_b = '0; req1_ctrl = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset state.
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    check("rst_rsp0_res", rsp0_res, 32'd0);
    check("rst_ready_none", {30'd0, req1_ready, req0_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) do_txn(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].ctrl, vecs[i].res, vecs[i].zero);

    // Contention with response ready tied high: grants alternate 0,1,0,1.
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd7; req0_ctrl = 4'd6;
    req1_valid = 1'b1; req1_a = 32'h0000_00F0; req1_b = 32'h0000_000F; req1_ctrl = 4'd1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    grants = 0; got_rsp0 = 1'b0; got_rsp1 = 1'b0;
    for (int cyc = 0; cyc < 40 && grants < 4; cyc++) begin
      #1;
      if (req0_ready && req1_ready) check("rr_both_ready", 32'd1, 32'd0);
      if (req0_ready) begin order[grants] = 0; grants++; end
      else if (req1_ready) begin order[grants] = 1; grants++; end
      if (rsp0_valid && !got_rsp0) begin
        got_rsp0 = 1'b1;
        check("rr_rsp0_res", rsp0_res, 32'd0);
        check("rr_rsp0_zero", {31'd0, rsp0_zero}, 32'd1);
      end
      if (rsp1_valid && !got_rsp1) begin
        got_rsp1 = 1'b1;
        check("rr_rsp1_res", rsp1_res, 32'h0000_00FF);
        check("rr_rsp1_zero", {31'd0, rsp1_zero}, 32'd0);
      end
      @(negedge clk);
    end
    if (grants < 4) check("rr_grant_timeout", grants, 32'd4);
    else for (int k = 0; k < 4; k++) check("rr_order", order[k], k % 2);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rr_saw_rsp", {30'd0, got_rsp1, got_rsp0}, 32'd3);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Response backpressure on port 0 while requester 1 waits.
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_ctrl = 4'd2;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd4; req1_ctrl = 4'd6;
    #1;
    check("bp_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("bp_req1_blocked", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    check("bp_exec_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      rsp1_ready = (c == 2);
      #1;
      check("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      check("bp_rsp0_res", rsp0_res, 32'd8);
      check("bp_rsp0_zero", {31'd0, rsp0_zero}, 32'd0);
      check("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
      check("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
      @(negedge clk);
    end
    rsp1_ready = 1'b0;
    rsp0_ready = 1'b1;
    #1;
    check("bp_release_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    check("bp_rsp0_cleared", {31'd0, rsp0_valid}, 32'd0);
    check("bp_req1_granted", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    check("bp_req1_alu_a", alu_a, 32'd10);
    @(negedge clk);
    check("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    check("bp_rsp1_res", rsp1_res, 32'd6);
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;

    // Reset during EXEC drops the transaction.
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd2; req1_ctrl = 4'd2;
    #1;
    check("rx_req1_ready", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    check("rx_exec_alu_b", alu_b, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rx_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("rx_alu_a", alu_a, 32'd0);
    check("rx_alu_b", alu_b, 32'd0);
    check("rx_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rx_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end
    do_txn(1'b1, 32'd1, 32'd2, 4'd2, 32'd3, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
